// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of committed stores draining to data memory in order,
// with a word-granular address match that stalls younger loads to pending stores.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_op,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    output logic                     dm_wr_en,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_data,
    output logic [1:0]               dm_op,
    output logic [31:0]              dm_pc,
    input  logic                     dm_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [1:0]       r_op   [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;
    logic w_match;

    assign st_ready = (r_count < FULL);
    assign dm_wr_en = (r_count != '0);
    assign w_push   = st_valid && st_ready;
    assign w_pop    = dm_wr_en && dm_ready;
    assign count    = r_count;

    assign dm_addr = dm_wr_en ? r_addr[r_head] : 32'h0;
    assign dm_data = dm_wr_en ? r_data[r_head] : 32'h0;
    assign dm_op   = dm_wr_en ? r_op[r_head]   : 2'b00;
    assign dm_pc   = dm_wr_en ? r_pc[r_head]   : 32'h0;

    // Entry payload carries no reset; validity is tracked by r_vld and the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
            r_op[r_tail]   <= st_op;
            r_pc[r_tail]   <= st_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) begin
                r_tail        <= r_tail + 1'b1;
                r_vld[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head        <= r_head + 1'b1;
                r_vld[r_head] <= 1'b0;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The head being popped this cycle is still valid, so it still raises a hazard.
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i][31:2] == ld_addr[31:2])) begin
                w_match = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_valid && w_match;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=4): directed vector table plus
// hand-written fill, wrap-around and asynchronous-reset sequences.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_op;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        dm_wr_en;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic [1:0]  dm_op;
    logic [31:0] dm_pc;
    logic        dm_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_op     (st_op),
        .st_pc     (st_pc),
        .st_ready  (st_ready),
        .dm_wr_en  (dm_wr_en),
        .dm_addr   (dm_addr),
        .dm_data   (dm_data),
        .dm_op     (dm_op),
        .dm_pc     (dm_pc),
        .dm_ready  (dm_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st_valid;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic [1:0]  st_op;
        logic        dm_ready;
        logic        ld_valid;
        logic [31:0] ld_addr;
        logic        e_st_ready;
        logic        e_wr_en;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_op;
        logic [2:0]  e_count;
        logic        e_hazard;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] op, input logic rdy);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_op    = op;
        st_pc    = a + 32'h1000;
        dm_ready = rdy;
    endtask

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        drive(1'b1, 32'h40, 32'h55, 2'b00, 1'b1);

        // Records: st_valid addr data op dm_ready ld_valid ld_addr | st_ready wr addr data op count haz
        vecs[0] = '{1'b0, 32'h0,   32'h0,        2'b00, 1'b1, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h0,   32'h0,        2'b00, 3'd0, 1'b0};
        vecs[1] = '{1'b1, 32'h10,  32'h12345678, 2'b00, 1'b1, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h0,   32'h0,        2'b00, 3'd0, 1'b0};
        vecs[2] = '{1'b0, 32'h0,   32'h0,        2'b00, 1'b1, 1'b0, 32'h0,
                    1'b1, 1'b1, 32'h10,  32'h12345678, 2'b00, 3'd1, 1'b0};
        vecs[3] = '{1'b0, 32'h0,   32'h0,        2'b00, 1'b1, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h0,   32'h0,        2'b00, 3'd0, 1'b0};
        // Same-cycle store is not compared against the load.
        vecs[4] = '{1'b1, 32'h104, 32'h000000ab, 2'b10, 1'b0, 1'b1, 32'h104,
                    1'b1, 1'b0, 32'h0,   32'h0,        2'b00, 3'd0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,   32'h0,        2'b00, 1'b0, 1'b1, 32'h107,
                    1'b1, 1'b1, 32'h104, 32'h000000ab, 2'b10, 3'd1, 1'b1};
        vecs[6] = '{1'b0, 32'h0,   32'h0,        2'b00, 1'b0, 1'b1, 32'h108,
                    1'b1, 1'b1, 32'h104, 32'h000000ab, 2'b10, 3'd1, 1'b0};
        vecs[7] = '{1'b0, 32'h0,   32'h0,        2'b00, 1'b0, 1'b0, 32'h107,
                    1'b1, 1'b1, 32'h104, 32'h000000ab, 2'b10, 3'd1, 1'b0};
        // Entry being popped still counts for the hazard.
        vecs[8] = '{1'b0, 32'h0,   32'h0,        2'b00, 1'b1, 1'b1, 32'h107,
                    1'b1, 1'b1, 32'h104, 32'h000000ab, 2'b10, 3'd1, 1'b1};
        vecs[9] = '{1'b0, 32'h0,   32'h0,        2'b00, 1'b1, 1'b1, 32'h107,
                    1'b1, 1'b0, 32'h0,   32'h0,        2'b00, 3'd0, 1'b0};

        // Reset state, with requests present that must be ignored.
        next_cycle();
        next_cycle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_wr_en", 32'(dm_wr_en), 32'd0);
        chk("rst_addr", dm_addr, 32'h0);
        chk("rst_pc", dm_pc, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].st_valid, vecs[i].st_addr, vecs[i].st_data, vecs[i].st_op,
                  vecs[i].dm_ready);
            ld_valid = vecs[i].ld_valid;
            ld_addr  = vecs[i].ld_addr;
            #1;
            chk($sformatf("v%0d_st_ready", i), 32'(st_ready), 32'(vecs[i].e_st_ready));
            chk($sformatf("v%0d_wr_en", i), 32'(dm_wr_en), 32'(vecs[i].e_wr_en));
            chk($sformatf("v%0d_addr", i), dm_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_data", i), dm_data, vecs[i].e_data);
            chk($sformatf("v%0d_op", i), 32'(dm_op), 32'(vecs[i].e_op));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_hazard", i), 32'(ld_hazard), 32'(vecs[i].e_hazard));
            if (vecs[i].e_wr_en) begin
                chk($sformatf("v%0d_pc", i), dm_pc, vecs[i].e_addr + 32'h1000);
            end
            next_cycle();
        end
        ld_valid = 1'b0;

        // Fill with dm_ready low: fifth store must be refused.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h200 + 32'(4 * k), 32'hd0 + 32'(k), 2'b00, 1'b0);
            #1;
            chk($sformatf("fill%0d_st_ready", k), 32'(st_ready), (k < 4) ? 32'd1 : 32'd0);
            next_cycle();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_st_ready", 32'(st_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
            #1;
            chk($sformatf("drain%0d_wr_en", k), 32'(dm_wr_en), 32'd1);
            chk($sformatf("drain%0d_addr", k), dm_addr, 32'h200 + 32'(4 * k));
            chk($sformatf("drain%0d_data", k), dm_data, 32'hd0 + 32'(k));
            next_cycle();
        end
        chk("drain_wr_en", 32'(dm_wr_en), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // Simultaneous push/pop at count 2; pointers wrap past index 3.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h300 + 32'(4 * k), 32'he0 + 32'(k), 2'b01, 1'b0);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h308 + 32'(4 * k), 32'he2 + 32'(k), 2'b01, 1'b1);
            #1;
            chk($sformatf("pp%0d_addr", k), dm_addr, 32'h300 + 32'(4 * k));
            chk($sformatf("pp%0d_data", k), dm_data, 32'he0 + 32'(k));
            next_cycle();
            chk($sformatf("pp%0d_count", k), 32'(count), 32'd2);
        end
        for (int k = 3; k < 5; k++) begin
            drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
            #1;
            chk($sformatf("pp%0d_addr", k), dm_addr, 32'h300 + 32'(4 * k));
            chk($sformatf("pp%0d_data", k), dm_data, 32'he0 + 32'(k));
            chk($sformatf("pp%0d_op", k), 32'(dm_op), 32'd1);
            next_cycle();
        end
        chk("pp_count", 32'(count), 32'd0);

        // Asynchronous reset between edges with three stores pending.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400 + 32'(4 * k), 32'hf0 + 32'(k), 2'b00, 1'b0);
            next_cycle();
        end
        chk("mr_count_pre", 32'(count), 32'd3);
        drive(1'b1, 32'h500, 32'h1, 2'b00, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_wr_en", 32'(dm_wr_en), 32'd0);
        chk("mr_addr", dm_addr, 32'h0);
        next_cycle();
        chk("mr_hold_count", 32'(count), 32'd0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mr_post%0d_wr_en", k), 32'(dm_wr_en), 32'd0);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
